// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - source/fifo-side bundle for fifo_wr_arbiter
//
// Ports carried:
//   req, req_dat, req_last   packet sources -> arbiter (word valid, packed words, last flag)
//   req_ack, grant           arbiter -> sources (word accepted, one-hot grant)
//   busy, pkt_err            arbiter status (packet in progress, truncation pulse)
//   fifo_wr_req, fifo_wr_dat arbiter -> fifo write port
//   fifo_wr_full, fifo_wr_used fifo -> arbiter write-side status
// Modports: slave = arbiter view, master = source/fifo environment view.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DAT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DAT_WIDTH-1:0] req_dat;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ack;
  logic [NUM_REQ-1:0]           grant;
  logic                         busy;
  logic                         pkt_err;
  logic                         fifo_wr_req;
  logic [DAT_WIDTH-1:0]         fifo_wr_dat;
  logic                         fifo_wr_full;
  logic [ADDR_WIDTH:0]          fifo_wr_used;

  modport slave (
    input  req, req_dat, req_last, fifo_wr_full, fifo_wr_used,
    output req_ack, grant, busy, pkt_err, fifo_wr_req, fifo_wr_dat
  );

  modport master (
    output req, req_dat, req_last, fifo_wr_full, fifo_wr_used,
    input  req_ack, grant, busy, pkt_err, fifo_wr_req, fifo_wr_dat
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-granular round-robin arbiter for the fifo write port
//
// Ports:
//   clk   write-side clock (fifo wr_clk)
//   aclr  asynchronous active-high reset
//   bus   fifo_wr_arbiter_if.slave: sources (req/req_dat/req_last -> req_ack/grant),
//         status (busy, pkt_err) and the fifo write port (fifo_wr_req/dat, full/used)
// Optional feature: FIFO_WR_ARB_ROOM_CHECK_EN - only grant when the fifo has room for a
// full MAX_PKT packet, so a granted packet never stalls on full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DAT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_PKT    = 16
) (
  input  logic              clk,
  input  logic              aclr,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_PKT + 1);

  typedef enum logic {IDLE, PKT} state_t;

  state_t               state;
  logic [NUM_REQ-1:0]   grant_q;
  logic [PW-1:0]        grant_idx;
  logic [PW-1:0]        ptr;
  logic [CW-1:0]        cnt;
  logic                 busy_q;
  logic                 pkt_err_q;

  logic [NUM_REQ-1:0]   accept;
  logic                 acc_any;
  logic                 acc_last;
  logic [DAT_WIDTH-1:0] dat_mux;
  logic                 sel_found;
  logic [PW-1:0]        sel_idx;
  logic [PW-1:0]        cand;
  logic                 room_ok;

  assign accept   = grant_q & bus.req & {NUM_REQ{~bus.fifo_wr_full}};
  assign acc_any  = |accept;
  assign acc_last = |(accept & bus.req_last);

  always_comb begin
    dat_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) dat_mux = dat_mux | bus.req_dat[i*DAT_WIDTH +: DAT_WIDTH];
    end
  end

  // Round-robin scan starting just after the last packet's owner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(ptr) + k) % NUM_REQ);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

`ifdef FIFO_WR_ARB_ROOM_CHECK_EN
  localparam int RW = ADDR_WIDTH + 2;
  logic [RW-1:0] room;
  assign room    = (RW'(1) << ADDR_WIDTH) - RW'(bus.fifo_wr_used);
  assign room_ok = (room >= RW'(MAX_PKT));
`else
  logic unused_wr_used;
  assign unused_wr_used = ^bus.fifo_wr_used;
  assign room_ok        = 1'b1;
`endif

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state     <= IDLE;
      grant_q   <= '0;
      grant_idx <= '0;
      ptr       <= PW'(NUM_REQ - 1);
      cnt       <= '0;
      busy_q    <= 1'b0;
      pkt_err_q <= 1'b0;
    end else begin
      pkt_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found && room_ok) begin
            grant_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
            grant_idx <= sel_idx;
            cnt       <= '0;
            busy_q    <= 1'b1;
            state     <= PKT;
          end
        end
        PKT: begin
          if (acc_any) begin
            // A word that hits MAX_PKT closes the packet even without last;
            // the source's remaining words re-arbitrate as a new packet.
            if (acc_last || cnt == CW'(MAX_PKT - 1)) begin
              grant_q   <= '0;
              ptr       <= grant_idx;
              cnt       <= '0;
              busy_q    <= 1'b0;
              pkt_err_q <= ~acc_last;
              state     <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ack     = accept;
  assign bus.fifo_wr_req = acc_any;
  assign bus.fifo_wr_dat = dat_mux;
  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.pkt_err     = pkt_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int MP = 4;

  logic clk = 1'b0;
  logic aclr = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DAT_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DAT_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_PKT(MP)) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d);
    bus.req      = r;
    bus.req_last = l;
    bus.req_dat  = d;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [3:0] g, input logic [3:0] ack,
                         input logic [7:0] dat);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".ack"}, 32'(bus.req_ack), 32'(ack));
    chk({tag, ".wr_req"}, 32'(bus.fifo_wr_req), 32'(|ack));
    chk({tag, ".wr_dat"}, 32'(bus.fifo_wr_dat), 32'(dat));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(|g));
  endtask

  logic [3:0] exp_g [4];
  logic [3:0] g;
  logic [7:0] d;

  initial begin
    bus.req = '0; bus.req_last = '0; bus.req_dat = '0;
    bus.fifo_wr_full = 1'b0; bus.fifo_wr_used = '0;
    exp_g = '{4'b0010, 4'b0000, 4'b1000, 4'b0000};
    #1;
    chk_bus("rst", 4'b0000, 4'b0000, 8'h00);
    chk("rst.pkt_err", 32'(bus.pkt_err), 32'd0);
    tick();
    tick();
    aclr = 1'b0;

    // Round robin between requesters 1 and 3, single-word packets
    drive(4'b1010, 4'b1111, {8'hD3, 8'hD2, 8'hD1, 8'hD0});
    chk_bus("rr_idle", 4'b0000, 4'b0000, 8'h00);
    for (int n = 0; n < 8; n++) begin
      tick();
      #1;
      g = exp_g[n % 4];
      d = (g == 4'b0010) ? 8'hD1 : (g == 4'b1000) ? 8'hD3 : 8'h00;
      chk_bus($sformatf("rr%0d", n), g, g, d);
    end
    drive(4'b0000, 4'b0000, 32'h0);

    // Requester 0 three-word packet while requester 1 waits
    tick();
    drive(4'b0011, 4'b0010, {8'h00, 8'h00, 8'hB0, 8'hA0});
    chk_bus("pk_idle", 4'b0000, 4'b0000, 8'h00);
    tick();
    drive(4'b0011, 4'b0010, {8'h00, 8'h00, 8'hB0, 8'hA0});
    chk_bus("pk_a0", 4'b0001, 4'b0001, 8'hA0);
    tick();
    drive(4'b0011, 4'b0010, {8'h00, 8'h00, 8'hB0, 8'hA1});
    chk_bus("pk_a1", 4'b0001, 4'b0001, 8'hA1);
    tick();
    drive(4'b0011, 4'b0011, {8'h00, 8'h00, 8'hB0, 8'hA2});
    chk_bus("pk_a2", 4'b0001, 4'b0001, 8'hA2);
    tick();
    drive(4'b0010, 4'b0010, {8'h00, 8'h00, 8'hB0, 8'h00});
    chk_bus("pk_bub", 4'b0000, 4'b0000, 8'h00);
    tick();
    drive(4'b0010, 4'b0010, {8'h00, 8'h00, 8'hB0, 8'h00});
    chk_bus("pk_b0", 4'b0010, 4'b0010, 8'hB0);
    tick();
    drive(4'b0100, 4'b0000, 32'h00C0_0000);
    chk_bus("pk_bub2", 4'b0000, 4'b0000, 8'h00);

    // Requester 2: req drop and fifo full mid-packet
    tick();
    drive(4'b0100, 4'b0000, 32'h00C0_0000);
    chk_bus("st_c0", 4'b0100, 4'b0100, 8'hC0);
    tick();
    drive(4'b0000, 4'b0000, 32'h00C1_0000);
    chk_bus("st_drop0", 4'b0100, 4'b0000, 8'hC1);
    tick();
    drive(4'b0000, 4'b0000, 32'h00C1_0000);
    chk_bus("st_drop1", 4'b0100, 4'b0000, 8'hC1);
    bus.fifo_wr_full = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      drive(4'b0100, 4'b0100, 32'h00C1_0000);
      chk_bus($sformatf("st_full%0d", n), 4'b0100, 4'b0000, 8'hC1);
    end
    tick();
    bus.fifo_wr_full = 1'b0;
    drive(4'b0100, 4'b0100, 32'h00C1_0000);
    chk_bus("st_c1", 4'b0100, 4'b0100, 8'hC1);
    tick();
    drive(4'b1000, 4'b0000, 32'hE100_0000);
    chk_bus("st_bub", 4'b0000, 4'b0000, 8'h00);

    // Requester 3: six words, last only on word 6, truncated at 4
    for (int w = 1; w <= 4; w++) begin
      tick();
      d = 8'(8'hE0 + w);
      drive(4'b1000, 4'b0000, {d, 24'h0});
      chk_bus($sformatf("mx_w%0d", w), 4'b1000, 4'b1000, d);
      chk($sformatf("mx_w%0d.pkt_err", w), 32'(bus.pkt_err), 32'd0);
    end
    tick();
    drive(4'b1000, 4'b0000, 32'hE500_0000);
    chk_bus("mx_bub", 4'b0000, 4'b0000, 8'h00);
    chk("mx_bub.pkt_err", 32'(bus.pkt_err), 32'd1);
    tick();
    drive(4'b1000, 4'b0000, 32'hE500_0000);
    chk_bus("mx_w5", 4'b1000, 4'b1000, 8'hE5);
    chk("mx_w5.pkt_err", 32'(bus.pkt_err), 32'd0);
    tick();
    drive(4'b1000, 4'b1000, 32'hE600_0000);
    chk_bus("mx_w6", 4'b1000, 4'b1000, 8'hE6);
    tick();
    drive(4'b1001, 4'b0001, {8'hF3, 8'h00, 8'h00, 8'hF0});
    chk_bus("mx_bub2", 4'b0000, 4'b0000, 8'h00);
    chk("mx_bub2.pkt_err", 32'(bus.pkt_err), 32'd0);

    // Move pointer to 0, then reset during word 2 of a requester-3 packet
    tick();
    drive(4'b1001, 4'b0001, {8'hF3, 8'h00, 8'h00, 8'hF0});
    chk_bus("ar_r0", 4'b0001, 4'b0001, 8'hF0);
    tick();
    drive(4'b1000, 4'b0000, {8'hF3, 24'h0});
    chk_bus("ar_bub", 4'b0000, 4'b0000, 8'h00);
    tick();
    drive(4'b1000, 4'b0000, {8'hF3, 24'h0});
    chk_bus("ar_w1", 4'b1000, 4'b1000, 8'hF3);
    tick();
    drive(4'b1000, 4'b0000, {8'hF4, 24'h0});
    chk_bus("ar_w2", 4'b1000, 4'b1000, 8'hF4);
    aclr = 1'b1;
    #1;
    chk_bus("ar_async", 4'b0000, 4'b0000, 8'h00);
    tick();
    aclr = 1'b0;
    drive(4'b1111, 4'b0000, {8'hD3, 8'hD2, 8'hD1, 8'hD0});
    chk_bus("ar_idle", 4'b0000, 4'b0000, 8'h00);
    tick();
    drive(4'b1111, 4'b0000, {8'hD3, 8'hD2, 8'hD1, 8'hD0});
    chk_bus("ar_first", 4'b0001, 4'b0001, 8'hD0);
    drive(4'b0001, 4'b0001, {8'hD3, 8'hD2, 8'hD1, 8'hD0});
    tick();
    bus.fifo_wr_used = 5'd13;
    drive(4'b0001, 4'b0001, {8'hD3, 8'hD2, 8'hD1, 8'hD0});
    chk_bus("ar_rel", 4'b0000, 4'b0000, 8'h00);

    // Room check: 3 free words is not enough for a 4-word packet
`ifdef FIFO_WR_ARB_ROOM_CHECK_EN
    tick();
    #1;
    chk_bus("rm_hold0", 4'b0000, 4'b0000, 8'h00);
    tick();
    #1;
    chk_bus("rm_hold1", 4'b0000, 4'b0000, 8'h00);
    bus.fifo_wr_used = 5'd12;
    tick();
    #1;
    chk_bus("rm_grant", 4'b0001, 4'b0001, 8'hD0);
`else
    tick();
    #1;
    chk_bus("rm_nochk", 4'b0001, 4'b0001, 8'hD0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
